weight_stream_packer: RTL and testbench

WEIGHT_STREAM_PACKER -- requirements
Module: weight_stream_packer

---
 rtl/weight_stream_packer.sv | 187 ++++++++++++++++++
 tb/tb_weight_stream_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_packer.sv
// weight_stream_packer
//
// Repacks the 64-bit DMA weight byte stream into 72-bit words for the weight
// store. Each output word holds nine consecutive stream bytes (one 3x3 kernel
// tap set). The lowest-addressed byte always sits in the lowest byte lane on
// both the input beat and the output word.
//
// Ports
//   clk            single clock, all logic on the rising edge
//   rst            synchronous, active-high reset
//   start          one-cycle pulse; latches the config and begins a load (IDLE only)
//   cfg_ci_groups  input-channel groups of 8, sampled on an accepted start
//   cfg_co_groups  output-channel groups of 8, sampled on an accepted start
//   s_tvalid/s_tready/s_tdata/s_tlast   AXI-Stream slave carrying the weight bytes
//   wr_en          weight-store write strobe, one 72-bit word per high cycle
//   wr_data        packed weight word, holds its last value while wr_en is low
//   busy           high whenever the packer is not idle
//   done           one-cycle pulse when a load finishes (normally or on error)
//   err_len        sticky length-error flag, cleared by the next accepted start
module weight_stream_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cfg_ci_groups,
    input  logic [7:0]  cfg_co_groups,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [63:0] s_tdata,
    input  logic        s_tlast,
    output logic        wr_en,
    output logic [71:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err_len
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [23:0]  words_total;
    logic [23:0]  beats_total;
    logic [23:0]  beat_cnt;
    logic [23:0]  word_cnt;
    logic [127:0] byte_buf;
    logic [4:0]   byte_cnt;

    logic [15:0]  grp_prod;
    logic [23:0]  prod_ext;
    logic         cfg_zero;
    logic         accept;
    logic         last_beat;
    logic         early_last;
    logic         emit;
    logic         final_word;

    logic [4:0]   cnt_after_emit;
    logic [127:0] buf_shifted;
    logic [127:0] beat_placed;
    logic [127:0] buf_next;
    logic [4:0]   cnt_next;

    // Per-load totals: words = groups*64, beats = groups*72 (9 bytes per word,
    // 8 bytes per beat). The largest product still fits comfortably in 24 bits.
    assign grp_prod = 16'(cfg_ci_groups) * 16'(cfg_co_groups);
    assign prod_ext = {8'd0, grp_prod};
    assign cfg_zero = (cfg_ci_groups == 8'd0) || (cfg_co_groups == 8'd0);

    // Ready is gated with rst so the slave never advertises space while a reset
    // is being applied, even if the state register still says LOAD.
    assign s_tready   = !rst && (state == ST_LOAD) && (beat_cnt < beats_total);
    assign accept     = s_tvalid && s_tready;
    assign last_beat  = accept && (beat_cnt == beats_total - 24'd1);
    assign early_last = accept && s_tlast && !last_beat;

    // A premature tlast abandons the load, so nothing more is written even if
    // a complete word is still sitting in the buffer.
    assign emit       = ((state == ST_LOAD) || (state == ST_DRAIN)) &&
                        (byte_cnt >= 5'd9) && !early_last;
    assign final_word = emit && (word_cnt == words_total - 24'd1);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Gearbox: the oldest bytes live in the low lanes of byte_buf. Emitting
    // shifts nine bytes out, then an accepted beat lands directly above the
    // bytes that remain. Lanes at or above byte_cnt are always zero, which is
    // what lets the new beat be ORed in. Worst case fill is 8+8 = 16 bytes, so
    // a 128-bit buffer never forces back-pressure.
    always_comb begin
        cnt_after_emit = emit ? (byte_cnt - 5'd9) : byte_cnt;
        buf_shifted    = emit ? (byte_buf >> 72) : byte_buf;
        beat_placed    = {64'd0, s_tdata} << {cnt_after_emit, 3'b000};
        buf_next       = accept ? (buf_shifted | beat_placed) : buf_shifted;
        cnt_next       = accept ? (cnt_after_emit + 5'd8) : cnt_after_emit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = cfg_zero ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (early_last) begin
                    state_next = ST_DONE;
                end else if (last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_word) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_total <= '0;
            beats_total <= '0;
            beat_cnt    <= '0;
            word_cnt    <= '0;
            byte_buf    <= '0;
            byte_cnt    <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            err_len     <= 1'b0;
        end else begin
            wr_en <= emit;
            if (emit) begin
                wr_data  <= byte_buf[71:0];
                word_cnt <= word_cnt + 24'd1;
            end

            if ((state == ST_IDLE) && start) begin
                words_total <= prod_ext << 6;
                beats_total <= (prod_ext << 6) + (prod_ext << 3);
                beat_cnt    <= '0;
                word_cnt    <= '0;
                byte_buf    <= '0;
                byte_cnt    <= '0;
                err_len     <= 1'b0;
            end else if (early_last) begin
                err_len  <= 1'b1;
                beat_cnt <= beat_cnt + 24'd1;
                byte_buf <= '0;
                byte_cnt <= '0;
            end else begin
                byte_buf <= buf_next;
                byte_cnt <= cnt_next;
                if (accept) begin
                    beat_cnt <= beat_cnt + 24'd1;
                end
                // Missing tlast on the final beat is flagged but the load
                // still completes with every word written.
                if (last_beat && !s_tlast) begin
                    err_len <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_stream_packer.sv
// tb_weight_stream_packer
//
// Self-checking bench for weight_stream_packer. Stream byte n carries the value
// (n + seed) mod 256, so every written word can be predicted from its index
// alone. A table of load scenarios is run in a loop, followed by hand-written
// sequences for the done timing of an empty config, the first-word latency,
// and a reset that abandons a load part-way through.
module tb_weight_stream_packer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_ci_groups;
    logic [7:0]  cfg_co_groups;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic        s_tlast;
    logic        wr_en;
    logic [71:0] wr_data;
    logic        busy;
    logic        done;
    logic        err_len;

    typedef struct {
        int ci;
        int co;
        int nbeats;
        int tlast_idx;
        bit gaps;
        bit busy_start;
        int min_words;
        int max_words;
        bit exp_err;
    } scen_t;

    scen_t scen [7];

    int checks_total  = 0;
    int checks_passed = 0;

    int mon_words        = 0;
    int mon_dones        = 0;
    int mon_bad          = 0;
    int mon_ready_cycles = 0;
    int words_base       = 0;
    int seed             = 0;

    weight_stream_packer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_ci_groups (cfg_ci_groups),
        .cfg_co_groups (cfg_co_groups),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] streamByte(input int n);
        int v;
        v = n + seed;
        return v[7:0];
    endfunction

    function automatic logic [63:0] beatData(input int j);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) d[8*b +: 8] = streamByte(8*j + b);
        return d;
    endfunction

    function automatic logic [71:0] wordData(input int k);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[8*i +: 8] = streamByte(9*k + i);
        return w;
    endfunction

    // Watches the write port mid-cycle, counting words, done pulses and ready
    // cycles, and checking each written word against the byte-counter model.
    always @(negedge clk) begin
        logic [71:0] exp_word;
        if (wr_en) begin
            exp_word = wordData(mon_words - words_base);
            if (wr_data !== exp_word) begin
                if (mon_bad < 3)
                    $display("[TB] bad word k=%0d got %h want %h",
                             mon_words - words_base, wr_data, exp_word);
                mon_bad++;
            end
            mon_words++;
        end
        if (done) mon_dones++;
        if (s_tready) mon_ready_cycles++;
    end

    task automatic checkOutput(input string name, input logic [71:0] act,
                               input logic [71:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Pulses start with the given config; returns at edge+1 after the pulse.
    task automatic startLoad(input int ci, input int co);
        seed          = seed + 17;
        words_base    = mon_words;
        cfg_ci_groups = 8'(ci);
        cfg_co_groups = 8'(co);
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        cfg_ci_groups = 8'hFF;
        cfg_co_groups = 8'hFF;
    endtask

    // Offers beats j0..n-1, optionally with idle gaps and a stray start pulse.
    task automatic sendBeats(input int j0, input int n, input int tlast_idx,
                             input bit gaps, input bit busy_start);
        int j;
        int stall;
        bit pulsed;
        bit acc;
        j      = j0;
        stall  = 0;
        pulsed = 1'b0;
        while (j < n) begin
            s_tvalid = !(gaps && ($urandom_range(0, 9) < 3));
            s_tdata  = beatData(j);
            s_tlast  = (j == tlast_idx);
            if (busy_start && !pulsed && j == 5) begin
                start         = 1'b1;
                cfg_ci_groups = 8'd3;
                cfg_co_groups = 8'd3;
                pulsed        = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            acc = s_tvalid && s_tready;
            @(posedge clk); #1;
            if (acc) begin
                j++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 50) begin
                    checkOutput("beat_timeout", 72'(j), 72'(n));
                    break;
                end
            end
        end
        start    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic waitDone(input int dones_base);
        int k;
        k = 0;
        while (mon_dones == dones_base && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input scen_t s);
        startLoad(s.ci, s.co);
        sendBeats(0, s.nbeats, s.tlast_idx, s.gaps, s.busy_start);
    endtask

    task automatic runScenario(input scen_t s, input string tag);
        int d0;
        int b0;
        int r0;
        int words;
        d0 = mon_dones;
        b0 = mon_bad;
        r0 = mon_ready_cycles;
        applyStimulus(s);
        waitDone(d0);
        words = mon_words - words_base;
        checkOutput({tag, "_done"}, 72'(mon_dones - d0), 72'(1));
        if (s.min_words == s.max_words)
            checkOutput({tag, "_words"}, 72'(words), 72'(s.min_words));
        else
            checkOutput({tag, "_words_in_range"},
                        72'(words >= s.min_words && words <= s.max_words), 72'(1));
        checkOutput({tag, "_bad_words"}, 72'(mon_bad - b0), 72'(0));
        checkOutput({tag, "_err_len"}, 72'(err_len), 72'(s.exp_err));
        checkOutput({tag, "_busy"}, 72'(busy), 72'(0));
        checkOutput({tag, "_tready"}, 72'(s_tready), 72'(0));
        if (s.nbeats == 0)
            checkOutput({tag, "_ready_cycles"}, 72'(mon_ready_cycles - r0), 72'(0));
    endtask

    initial begin
        int d0;
        int b0;
        logic [71:0] word0;

        scen[0] = '{8, 16, 9216, 9215, 1'b0, 1'b0, 8192, 8192, 1'b0};
        scen[1] = '{8, 16, 9216, 9215, 1'b1, 1'b0, 8192, 8192, 1'b0};
        scen[2] = '{1, 1, 40, 39, 1'b0, 1'b0, 0, 36, 1'b1};
        scen[3] = '{1, 1, 72, -1, 1'b0, 1'b0, 64, 64, 1'b1};
        scen[4] = '{0, 5, 0, -1, 1'b0, 1'b0, 0, 0, 1'b0};
        scen[5] = '{2, 1, 144, 143, 1'b1, 1'b1, 128, 128, 1'b0};
        scen[6] = '{1, 0, 0, -1, 1'b0, 1'b0, 0, 0, 1'b0};

        rst           = 1'b1;
        start         = 1'b0;
        cfg_ci_groups = 8'd0;
        cfg_co_groups = 8'd0;
        s_tvalid      = 1'b0;
        s_tdata       = 64'd0;
        s_tlast       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tready", 72'(s_tready), 72'(0));
        checkOutput("rst_wr_en", 72'(wr_en), 72'(0));
        checkOutput("rst_wr_data", wr_data, 72'(0));
        checkOutput("rst_busy", 72'(busy), 72'(0));
        checkOutput("rst_done", 72'(done), 72'(0));
        checkOutput("rst_err_len", 72'(err_len), 72'(0));
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_busy", 72'(busy), 72'(0));
        checkOutput("idle_tready", 72'(s_tready), 72'(0));

        for (int i = 0; i < 7; i++) begin
            $display("[TB] scenario %0d: ci=%0d co=%0d beats=%0d",
                     i, scen[i].ci, scen[i].co, scen[i].nbeats);
            runScenario(scen[i], $sformatf("scen%0d", i));
        end

        // Empty config: done is high exactly one cycle after the start edge.
        d0 = mon_dones;
        startLoad(0, 5);
        checkOutput("zero_done_next", 72'(done), 72'(1));
        checkOutput("zero_busy_next", 72'(busy), 72'(1));
        @(posedge clk); #1;
        checkOutput("zero_done_after", 72'(done), 72'(0));
        checkOutput("zero_busy_after", 72'(busy), 72'(0));
        checkOutput("zero_wr_en", 72'(mon_words - words_base), 72'(0));

        // First-word latency: beats at E0, E1, first wr_en after E2.
        d0 = mon_dones;
        b0 = mon_bad;
        startLoad(1, 1);
        word0    = wordData(0);
        s_tvalid = 1'b1;
        s_tdata  = beatData(0);
        @(posedge clk); #1;
        s_tdata  = beatData(1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        checkOutput("lat_e1_wr_en", 72'(wr_en), 72'(0));
        @(posedge clk); #1;
        checkOutput("lat_e2_wr_en", 72'(wr_en), 72'(1));
        checkOutput("lat_e2_wr_data", wr_data, word0);
        @(posedge clk); #1;
        checkOutput("lat_e3_wr_en", 72'(wr_en), 72'(0));
        checkOutput("lat_e3_wr_data_hold", wr_data, word0);
        sendBeats(2, 72, 71, 1'b0, 1'b0);
        waitDone(d0);
        checkOutput("lat_words", 72'(mon_words - words_base), 72'(64));
        checkOutput("lat_bad_words", 72'(mon_bad - b0), 72'(0));
        checkOutput("lat_done", 72'(mon_dones - d0), 72'(1));

        // Reset part-way through a load abandons it without a done pulse.
        d0 = mon_dones;
        startLoad(2, 2);
        sendBeats(0, 100, -1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_tready", 72'(s_tready), 72'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midrst_busy", 72'(busy), 72'(0));
        checkOutput("midrst_wr_en", 72'(wr_en), 72'(0));
        checkOutput("midrst_err_len", 72'(err_len), 72'(0));
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("midrst_no_done", 72'(mon_dones - d0), 72'(0));
        runScenario('{1, 1, 72, 71, 1'b0, 1'b0, 64, 64, 1'b0}, "after_rst");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
